// File: rtl/decod_pipe.sv
// Registered select decoder with one-hot, thermometer and sticky-accumulate modes.
// One output register sits behind a valid/ready handshake on both sides.
module decod_pipe #(
  parameter int SEL_W      = 4,
  parameter int OUT_W      = 16,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dout,
  output logic             oor
);

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'd0,
    MODE_THERM  = 2'd1,
    MODE_ACCUM  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  localparam logic [OUT_W-1:0] IDLE_DOUT = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] therm;
  logic [OUT_W-1:0] base;
  logic [OUT_W-1:0] pat;
  logic [OUT_W-1:0] acc_next;
  logic             in_range;
  logic             oor_next;
  logic             accept;
  mode_t            mode_e;

  // Handshake: a beat moves on a rising edge where valid & ready are both high.
  // The output register accepts when it is empty or being drained this cycle;
  // while it holds undrained data every output stays frozen.
  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign mode_e   = mode_t'(mode);

  // Full-width compare so non-power-of-2 widths never alias onto a valid line.
  assign in_range = (32'(sel) < 32'(OUT_W));

  always_comb begin
    onehot = '0;
    therm  = '0;
    for (int k = 0; k < OUT_W; k++) begin
      onehot[k] = (32'(k) == 32'(sel));
      therm[k]  = (32'(k) <= 32'(sel));
    end
  end

  always_comb begin
    pat      = '0;
    oor_next = 1'b0;
    base     = clr ? '0 : acc;
    acc_next = base;
    if (en) begin
      if (!in_range) begin
        oor_next = 1'b1;
      end else begin
        case (mode_e)
          MODE_THERM: pat = therm;
          MODE_ACCUM: begin
            pat      = base | onehot;
            acc_next = pat;
          end
          default:    pat = onehot;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= IDLE_DOUT;
      oor       <= 1'b0;
      acc       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      dout      <= (ACTIVE_LOW != 0) ? ~pat : pat;
      oor       <= oor_next;
      acc       <= acc_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decod_pipe.sv
// Bench for decod_pipe: default, OUT_W=10 and ACTIVE_LOW=1 instances on shared stimulus,
// table-driven beats plus backpressure and reset-while-stalled sequences.
module tb_decod_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [3:0]  sel;
  logic        en;
  logic [1:0]  mode;
  logic        clr;
  logic        out_ready;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic        oor0, oor1, oor2;
  logic [15:0] dout0;
  logic [9:0]  dout1;
  logic [15:0] dout2;

  decod_pipe u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .sel(sel), .en(en),
    .mode(mode), .clr(clr), .out_valid(ov0), .out_ready(out_ready), .dout(dout0), .oor(oor0)
  );

  decod_pipe #(.OUT_W(10)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .sel(sel), .en(en),
    .mode(mode), .clr(clr), .out_valid(ov1), .out_ready(out_ready), .dout(dout1), .oor(oor1)
  );

  decod_pipe #(.ACTIVE_LOW(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .sel(sel), .en(en),
    .mode(mode), .clr(clr), .out_valid(ov2), .out_ready(out_ready), .dout(dout2), .oor(oor2)
  );

  typedef struct {
    logic [3:0]  sel;
    logic        en;
    logic [1:0]  mode;
    logic        clr;
    logic [16:0] exp;
  } vec_t;

  vec_t        vecs[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [16:0] cur_exp;
  logic [16:0] exp_q0[$];
  logic [10:0] exp_q1[$];
  logic [16:0] exp_q2[$];
  logic [15:0] acc1_m;
  logic [15:0] acc2_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input int s, input logic e, input int m, input logic c,
                              input logic [16:0] x);
    vec_t v;
    v.sel  = 4'(s);
    v.en   = e;
    v.mode = 2'(m);
    v.clr  = c;
    v.exp  = x;
    return v;
  endfunction

  // Returns {next_acc[15:0], oor, pattern[15:0]} for an OUT_W of ow.
  function automatic logic [32:0] model(input int ow, input logic [3:0] s, input logic e,
                                        input logic [1:0] m, input logic c,
                                        input logic [15:0] a);
    logic [15:0] p, na, oh;
    logic        o;
    p  = '0;
    o  = 1'b0;
    na = c ? 16'h0 : a;
    oh = 16'h1 << s;
    if (e) begin
      if (int'(s) >= ow) o = 1'b1;
      else if (m == 2'd1) p = (oh << 1) - 16'h1;
      else if (m == 2'd2) begin
        p  = na | oh;
        na = p;
      end else p = oh;
    end
    return {na, o, p};
  endfunction

  // Scoreboard: outputs checked against the queue head, accepts push new expectations.
  always @(negedge clk) begin
    logic [32:0] r1, r2;
    logic        ev0, ev1, ev2;
    if (rst) begin
      check("in_ready_during_rst", 32'({rdy0, rdy1, rdy2}), 32'(0));
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
      acc1_m = '0;
      acc2_m = '0;
    end else begin
      ev0 = (exp_q0.size() != 0);
      ev1 = (exp_q1.size() != 0);
      ev2 = (exp_q2.size() != 0);
      check("out_valid0", 32'(ov0), 32'(ev0));
      check("out_valid1", 32'(ov1), 32'(ev1));
      check("out_valid2", 32'(ov2), 32'(ev2));
      check("in_ready0", 32'(rdy0), 32'(!ev0 || out_ready));
      check("in_ready1", 32'(rdy1), 32'(!ev1 || out_ready));
      check("in_ready2", 32'(rdy2), 32'(!ev2 || out_ready));
      if (ov0 && ev0) begin
        check("dout0", 32'({oor0, dout0}), 32'(exp_q0[0]));
        if (out_ready) void'(exp_q0.pop_front());
      end
      if (ov1 && ev1) begin
        check("dout1", 32'({oor1, dout1}), 32'(exp_q1[0]));
        if (out_ready) void'(exp_q1.pop_front());
      end
      if (ov2 && ev2) begin
        check("dout2", 32'({oor2, dout2}), 32'(exp_q2[0]));
        if (out_ready) void'(exp_q2.pop_front());
      end
      if (in_valid && rdy0) begin
        exp_q0.push_back(cur_exp);
        r1     = model(10, sel, en, mode, clr, acc1_m);
        acc1_m = r1[32:17];
        exp_q1.push_back({r1[16], r1[9:0]});
        r2     = model(16, sel, en, mode, clr, acc2_m);
        acc2_m = r2[32:17];
        exp_q2.push_back({r2[16], ~r2[15:0]});
      end
    end
  end

  // Presents a beat and returns one edge after it is accepted; waits = stalled cycles.
  task automatic send(input vec_t v, output int waits);
    logic done;
    in_valid = 1'b1;
    sel      = v.sel;
    en       = v.en;
    mode     = v.mode;
    clr      = v.clr;
    cur_exp  = v.exp;
    waits    = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (rdy0) done = 1'b1;
      else begin
        waits++;
        if (waits > 50) begin
          check("accept_timeout", 32'(0), 32'(1));
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          total_waits;
    logic [16:0] t;

    rst = 1'b1; in_valid = 1'b1; sel = 4'd3; en = 1'b1; mode = 2'd0; clr = 1'b0;
    out_ready = 1'b1; cur_exp = 17'h1ffff;

    for (int i = 0; i < 16; i++) vecs.push_back(mk(i, 1'b1, 0, 1'b0, 17'h1 << i));
    vecs.push_back(mk(5,  1'b0, 0, 1'b0, 17'h00000));
    vecs.push_back(mk(3,  1'b1, 1, 1'b0, 17'h0000f));
    vecs.push_back(mk(15, 1'b1, 1, 1'b0, 17'h0ffff));
    vecs.push_back(mk(0,  1'b1, 1, 1'b0, 17'h00001));
    vecs.push_back(mk(2,  1'b1, 2, 1'b0, 17'h00004));
    vecs.push_back(mk(7,  1'b1, 2, 1'b0, 17'h00084));
    vecs.push_back(mk(2,  1'b1, 2, 1'b0, 17'h00084));
    vecs.push_back(mk(1,  1'b1, 2, 1'b1, 17'h00002));
    for (int i = 0; i < 16; i++) begin
      t = (17'h1 << (i + 1)) - 17'h1;
      vecs.push_back(mk(i, 1'b1, 2, 1'b0, {1'b0, t[15:0] | 16'h0002}));
    end
    vecs.push_back(mk(5,  1'b1, 2, 1'b0, 17'h0ffff));
    vecs.push_back(mk(4,  1'b1, 3, 1'b0, 17'h00010));
    vecs.push_back(mk(12, 1'b1, 0, 1'b0, 17'h01000));
    vecs.push_back(mk(9,  1'b1, 0, 1'b0, 17'h00200));
    vecs.push_back(mk(3,  1'b1, 2, 1'b1, 17'h00008));
    vecs.push_back(mk(12, 1'b1, 2, 1'b0, 17'h01008));
    vecs.push_back(mk(0,  1'b1, 2, 1'b0, 17'h01009));
    vecs.push_back(mk(5,  1'b0, 2, 1'b1, 17'h00000));
    vecs.push_back(mk(1,  1'b1, 2, 1'b0, 17'h00002));
    vecs.push_back(mk(4,  1'b1, 2, 1'b0, 17'h00012));
    vecs.push_back(mk(7,  1'b1, 0, 1'b1, 17'h00080));
    vecs.push_back(mk(0,  1'b1, 2, 1'b0, 17'h00001));
    vecs.push_back(mk(10, 1'b1, 1, 1'b0, 17'h007ff));

    // Reset with a request presented: it must be dropped.
    idle(2);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'({ov0, ov1, ov2}), 32'(0));
    check("rst_dout0", 32'({oor0, dout0}), 32'(0));
    check("rst_dout1", 32'({oor1, dout1}), 32'(0));
    check("rst_dout2_active_low", 32'({oor2, dout2}), 32'(17'h0ffff));
    @(posedge clk);
    #1;

    total_waits = 0;
    foreach (vecs[i]) begin
      send(vecs[i], w);
      total_waits += w;
    end
    in_valid = 1'b0;
    check("table_no_stall", 32'(total_waits), 32'(0));
    idle(3);

    // Backpressure: one beat held for 5 cycles, then drain and accept in one cycle.
    out_ready = 1'b0;
    send(mk(6, 1'b1, 0, 1'b0, 17'h00040), w);
    check("bp_first_accept_wait", 32'(w), 32'(0));
    sel = 4'd8; en = 1'b1; mode = 2'd0; clr = 1'b0; cur_exp = 17'h00100;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 32'(rdy0), 32'(0));
      check("bp_dout_stable", 32'({ov0, oor0, dout0}), 32'(18'h20040));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(rdy0), 32'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_beat", 32'({ov0, oor0, dout0}), 32'(18'h20100));
    idle(2);

    // Reset while stalled: pending beat and accumulator are discarded.
    out_ready = 1'b0;
    send(mk(3, 1'b1, 2, 1'b1, 17'h00008), w);
    idle(2);
    rst = 1'b1; sel = 4'd9; mode = 2'd2; clr = 1'b0; cur_exp = 17'h1ffff;
    @(negedge clk);
    check("rst_stall_in_ready", 32'(rdy0), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst_stall_out_valid", 32'({ov0, ov1, ov2}), 32'(0));
    check("rst_stall_dout2", 32'(dout2), 32'(16'hffff));
    @(posedge clk);
    #1;
    send(mk(1, 1'b1, 2, 1'b0, 17'h00002), w);
    in_valid = 1'b0;
    @(negedge clk);
    check("acc_cleared_by_rst", 32'({ov0, oor0, dout0}), 32'(18'h20002));
    idle(3);

    check("queues_drained", 32'(exp_q0.size() + exp_q1.size() + exp_q2.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decod_pipe.md
Name: decod_pipe

Overview:
- Parametrised, registered successor to the 4-to-16 enable-gated decoder.
- Decodes a SEL_W-bit select into an OUT_W-bit pattern in one of three modes: one-hot, thermometer, or sticky-accumulate.
- Input and output use valid/ready handshakes, with one pipeline register of latency.
- Sits between a command source and per-line consumers, e.g. bank/row select and interrupt-mask generation.

Parameters:
- SEL_W, 4, select width in bits.
- OUT_W, 16, decoded output width; legal range 2..2**SEL_W. Selects >= OUT_W are out of range.
- ACTIVE_LOW, 0, if 1 then dout is bitwise inverted at the output register. oor and the valid/ready signals are unaffected.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at the clk edge.
- sel  in  SEL_W  select index; bit SEL_W-1 is MSB.
- en  in  1  decode enable, sampled with the request.
- mode  in  2  0 = one-hot, 1 = thermometer, 2 = accumulate, 3 = reserved (treated as 0).
- clr  in  1  clears the accumulator; sampled only on an accepted request.
- out_valid  out  1  output register holds data.
- out_ready  in  1  consumer takes data when out_valid & out_ready.
- dout  out  OUT_W  decoded pattern, registered.
- oor  out  1  registered flag: sel >= OUT_W on this beat.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, dout=0 (all ones if ACTIVE_LOW), oor=0, acc=0.
  - in_ready=0 while rst is high.
  - A request presented during reset is dropped. A beat pending in the output register is discarded.
- Handshake:
  - in_ready = !rst & (!out_valid | out_ready), combinational. This gives full throughput with back-to-back beats.
  - Accept at edge N → out_valid=1 with the result from edge N onward. Latency is 1 cycle.
  - out_valid=1 & out_ready=0: dout, oor and out_valid hold stable, and in_ready=0.
  - Drain without a new accept → out_valid=0 next cycle. dout holds its last value; it is don't-care when not valid.
- Decode, raw pattern p before inversion:
  - en=0: p=0, oor=0, acc is unchanged, and clr is still honoured. Matches the legacy enable-gated behaviour.
  - en=1 & sel >= OUT_W: p=0, oor=1, acc is unchanged (except clr).
  - mode 0: p[k] = (k == sel).
  - mode 1: p[k] = (k <= sel). sel=0 → only bit 0 set; sel=OUT_W-1 → all ones.
  - mode 2:
    - base = clr ? 0 : acc.
    - p = base | onehot(sel).
    - acc <= p.
    - Repeated selects are idempotent. Once all bits are set, acc saturates at all ones and does not wrap.
  - clr on an accepted beat in modes 0/1 clears acc; p is unaffected.
  - acc changes only on accepted beats.
- Output: dout <= ACTIVE_LOW ? ~p : p.
- Mode switching between beats is allowed at any time. acc persists across non-accumulate beats.
- Non-power-of-2 OUT_W: comparisons use full-width sel; no truncation or modulo.

Test Plan:
- Defaults; sweep sel 0..15, mode 0, en=1, out_ready=1, back-to-back → dout = 1<<sel one cycle after each accept. The 16 beats take 16 cycles and in_ready stays 1. Sel 15 → 0x8000, sel 0 → 0x0001.
- en=0 on sel=5 → dout=0x0000, oor=0. Same beat with ACTIVE_LOW=1 → dout=0xFFFF.
- mode 1, sel=3 → 0x000F; sel=15 → 0xFFFF; sel=0 → 0x0001.
- mode 2, sels 2, 7, 2 → dout 0x0004, 0x0084, 0x0084. Then clr=1 with sel=1 → 0x0002. Then all 16 sels → 0xFFFF and stays 0xFFFF.
- OUT_W=10: sel=12 → dout=0, oor=1, acc unchanged. Next beat sel=9 in mode 0 → 0x200, oor=0.
- Backpressure: hold out_ready=0 after one accept → in_ready=0 and dout stable for 5 cycles. Release → drain plus new accept in the same cycle. Assert rst mid-stall → out_valid=0, acc=0 the next cycle.
